wide_and8: RTL and testbench

- 8-operand bitwise AND reduction: q = a & b & c & d & e & f & g & h, per bit, over WIDTH-bit operands.
- Used as a mask/qualifier combiner wherever several enable or permission vectors must all be set.
- Built as a parameterised AND tree with a single registered output stage.
- One clock; a valid flag travels alongside the data.

---
 rtl/wide_and8_if.sv | 33 +++
 rtl/wide_and8.sv | 86 ++++++++
 tb/tb_wide_and8.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/wide_and8_if.sv
// Operand/result bundle for wide_and8.
// Master drives operands; slave returns the registered AND.
interface wide_and8_if #(
  parameter int WIDTH = 8
);
  logic             i_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] q;
  logic             o_valid;

  modport master (
    output i_valid,
    output a, b, c, d,
    output e, f, g, h,
    input  q,
    input  o_valid
  );

  modport slave (
    input  i_valid,
    input  a, b, c, d,
    input  e, f, g, h,
    output q,
    output o_valid
  );
endinterface

// File: rtl/wide_and8.sv
// 8-operand bitwise AND reduction.
// Combinational AND tree of configurable fan-in, one output register.
module wide_and8 #(
  parameter int Port_Num = 2,
  parameter int WIDTH    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  wide_and8_if.slave bus
);

  logic [WIDTH-1:0] ops [8];
  logic [WIDTH-1:0] root;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic             vld_d;
  logic             vld_q;

  assign ops[0] = bus.a;
  assign ops[1] = bus.b;
  assign ops[2] = bus.c;
  assign ops[3] = bus.d;
  assign ops[4] = bus.e;
  assign ops[5] = bus.f;
  assign ops[6] = bus.g;
  assign ops[7] = bus.h;

  if (WIDTH < 1) begin : g_bad_width
    $error("wide_and8: WIDTH must be >= 1");
  end

  if (Port_Num == 2) begin : g_fan2
    logic [WIDTH-1:0] l1 [4];
    logic [WIDTH-1:0] l2 [2];

    for (genvar i = 0; i < 4; i++) begin : g_l1
      assign l1[i] = ops[2*i] & ops[2*i+1];
    end

    for (genvar i = 0; i < 2; i++) begin : g_l2
      assign l2[i] = l1[2*i] & l1[2*i+1];
    end

    assign root = l2[0] & l2[1];
  end else if (Port_Num == 4) begin : g_fan4
    logic [WIDTH-1:0] l1 [2];

    for (genvar i = 0; i < 2; i++) begin : g_l1
      assign l1[i] = ops[4*i]   & ops[4*i+1]
                   & ops[4*i+2] & ops[4*i+3];
    end

    assign root = l1[0] & l1[1];
  end else if (Port_Num == 8) begin : g_fan8
    assign root = ops[0] & ops[1]
                & ops[2] & ops[3]
                & ops[4] & ops[5]
                & ops[6] & ops[7];
  end else begin : g_bad_fan
    $error("wide_and8: Port_Num must be 2, 4 or 8");
    assign root = '0;
  end

  // q only moves on valid input; o_valid marks a fresh result.
  always_comb begin
    q_d   = q_q;
    vld_d = bus.i_valid;
    if (bus.i_valid) begin
      q_d = root;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      vld_q <= vld_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.o_valid = vld_q;

endmodule

// File: tb/tb_wide_and8.sv
// Directed/table bench for wide_and8.
// Runs fan-in 2, 4 and 8 builds side by side on identical stimulus.
module tb_wide_and8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  wide_and8_if #(.WIDTH(8)) if2 ();
  wide_and8_if #(.WIDTH(8)) if4 ();
  wide_and8_if #(.WIDTH(8)) if8 ();

  assign if4.i_valid = if2.i_valid;
  assign if4.a = if2.a;
  assign if4.b = if2.b;
  assign if4.c = if2.c;
  assign if4.d = if2.d;
  assign if4.e = if2.e;
  assign if4.f = if2.f;
  assign if4.g = if2.g;
  assign if4.h = if2.h;

  assign if8.i_valid = if2.i_valid;
  assign if8.a = if2.a;
  assign if8.b = if2.b;
  assign if8.c = if2.c;
  assign if8.d = if2.d;
  assign if8.e = if2.e;
  assign if8.f = if2.f;
  assign if8.g = if2.g;
  assign if8.h = if2.h;

  wide_and8 #(.Port_Num(2), .WIDTH(8)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
  );

  wide_and8 #(.Port_Num(4), .WIDTH(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  wide_and8 #(.Port_Num(8), .WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            iv;
    logic [7:0][7:0] ops;
    logic [7:0]      q;
    logic            ov;
  } vec_t;

  vec_t vecs [16];

  task automatic drive(input logic iv, input logic [7:0][7:0] ops);
    if2.i_valid = iv;
    if2.a = ops[0];
    if2.b = ops[1];
    if2.c = ops[2];
    if2.d = ops[3];
    if2.e = ops[4];
    if2.f = ops[5];
    if2.g = ops[6];
    if2.h = ops[7];
  endtask

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] eq,
                         input logic ev);
    chk({nm, " q p2"},  if2.q, eq);
    chk({nm, " q p4"},  if4.q, eq);
    chk({nm, " q p8"},  if8.q, eq);
    chk({nm, " ov p2"}, {7'd0, if2.o_valid}, {7'd0, ev});
    chk({nm, " ov p4"}, {7'd0, if4.o_valid}, {7'd0, ev});
    chk({nm, " ov p8"}, {7'd0, if8.o_valid}, {7'd0, ev});
  endtask

  function automatic logic [7:0][7:0] fill(input logic [7:0] v);
    logic [7:0][7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  initial begin
    logic [7:0][7:0] ops;
    logic [7:0]      m;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{1'b1, fill(8'hFF), 8'hFF, 1'b1};
    for (int i = 0; i < 8; i++) begin
      ops    = fill(8'hFF);
      ops[i] = 8'h7E;
      vecs[1+i] = '{1'b1, ops, 8'h7E, 1'b1};
    end
    ops = {8'h7A, 8'hDA, 8'h5F, 8'hFA, 8'h7E, 8'h5B, 8'h7F, 8'h5A};
    vecs[9]  = '{1'b1, ops, 8'h5A, 1'b1};
    vecs[10] = '{1'b0, fill(8'h00), 8'h5A, 1'b0};
    vecs[11] = '{1'b0, fill(8'hFF), 8'h5A, 1'b0};
    ops    = fill(8'hFF);
    ops[3] = 8'h00;
    vecs[12] = '{1'b1, ops, 8'h00, 1'b1};
    ops = {8'hF1, 8'h33, 8'hF1, 8'h33, 8'hF1, 8'h33, 8'hF1, 8'h33};
    vecs[13] = '{1'b1, ops, 8'h31, 1'b1};
    vecs[14] = '{1'b1, fill(8'h81), 8'h81, 1'b1};
    ops    = fill(8'hFF);
    ops[0] = 8'hAA;
    ops[7] = 8'h55;
    vecs[15] = '{1'b1, ops, 8'h00, 1'b1};

    // Reset held across edges with all-ones valid input.
    rst_n = 1'b0;
    drive(1'b1, fill(8'hFF));
    #1;
    chk_all("reset async", 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset held", 8'h00, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].iv, vecs[i].ops);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].ov);
    end

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 8; i++) ops[i] = 8'($urandom_range(0, 127));
      m = 8'hFF;
      for (int i = 0; i < 8; i++) m = m & ops[i];
      drive(1'b1, ops);
      @(posedge clk);
      #1;
      chk_all($sformatf("rand%0d", n), m, 1'b1);
      chk("rand msb", {7'd0, if2.q[7]}, 8'h00);
    end

    // Mid-stream reset between edges while a result is valid.
    drive(1'b1, fill(8'hC3));
    @(posedge clk);
    #1;
    chk_all("pre-rst", 8'hC3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("mid rst", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk_all("mid rst edge", 8'h00, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, fill(8'h3C));
    @(posedge clk);
    #1;
    chk_all("post rst", 8'h3C, 1'b1);
    drive(1'b0, fill(8'h00));
    @(posedge clk);
    #1;
    chk_all("post hold", 8'h3C, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
